ulight_fifo_status_poller: RTL and testbench

Avalon-MM read master that polls a one-bit status PIO slave of the ulight FIFO subsystem (e.g. TX-FIFO-empty) from fabric logic, so the HPS no longer has to. It issues periodic single reads of slave address 0 and debounces bit 0 of the returned word. It presents a stable status bit with rise/fall event pulses and flags transfers that never complete.

---
 rtl/ulight_fifo_poll_pkg.sv | 26 ++
 rtl/ulight_fifo_status_poller_if.sv | 24 ++
 rtl/ulight_fifo_poll_timer.sv | 30 +++
 rtl/ulight_fifo_status_poller.sv | 133 +++++++++++++
 tb/tb_ulight_fifo_status_poller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ulight_fifo_poll_pkg.sv
// Shared types and sizing helpers for the ulight FIFO status poller.
package ulight_fifo_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    EVAL
  } poll_state_e;

  localparam logic [1:0] STATUS_ADDR = 2'd0;

  localparam int unsigned DEF_POLL_PERIOD  = 64;
  localparam int unsigned DEF_TIMEOUT      = 16;
  localparam int unsigned DEF_STABLE_COUNT = 2;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned INTERVAL_W = cnt_width(DEF_POLL_PERIOD - 1);
  localparam int unsigned TIMEOUT_W  = cnt_width(DEF_TIMEOUT);
  localparam int unsigned DEBOUNCE_W = cnt_width(DEF_STABLE_COUNT);

endpackage

// File: rtl/ulight_fifo_status_poller_if.sv
// Avalon-MM read-only bus between the status poller (master) and the PIO slave.
interface ulight_fifo_status_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/ulight_fifo_poll_timer.sv
// Reloadable interval counter; decrements every cycle and saturates at zero.
module ulight_fifo_poll_timer
  import ulight_fifo_poll_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_POLL_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  output logic expired
);

  localparam int unsigned W = cnt_width(PERIOD - 1);
  localparam logic [W-1:0] RELOAD_VAL = W'(PERIOD - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (reload) begin
      count <= RELOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ulight_fifo_status_poller.sv
// Periodic Avalon-MM poller of a one-bit status PIO with debounce and edge pulses.
// Define POLLER_IRQ_EN to add a sticky irq output with irq_ack clear.
module ulight_fifo_status_poller
  import ulight_fifo_poll_pkg::*;
#(
  parameter int unsigned POLL_PERIOD  = DEF_POLL_PERIOD,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic poll_now,
  ulight_fifo_status_poller_if.master avm,
  output logic status,
  output logic status_valid,
  output logic status_rise,
  output logic status_fall,
  output logic timeout_err
`ifdef POLLER_IRQ_EN
  ,
  output logic irq,
  input  logic irq_ack
`endif
);

  localparam int unsigned TO_W = cnt_width(TIMEOUT);
  localparam int unsigned DB_W = cnt_width(STABLE_COUNT);

  poll_state_e       state;
  logic              pending;
  logic              sample;
  logic              read_q;
  logic [TO_W-1:0]   wait_cnt;
  logic [DB_W-1:0]   deb_cnt;
  logic              expired;
  logic              start;
  logic              unused_rdata;

  assign unused_rdata    = ^avm.avm_readdata[31:1];
  assign avm.avm_address = STATUS_ADDR;
  assign avm.avm_read    = read_q;

  assign start = (state == IDLE) && enable && (expired || pending || poll_now);

  ulight_fifo_poll_timer #(
    .PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .reload (start),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      sample       <= 1'b0;
      read_q       <= 1'b0;
      wait_cnt     <= '0;
      deb_cnt      <= '0;
      status       <= 1'b0;
      status_valid <= 1'b0;
      status_rise  <= 1'b0;
      status_fall  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      status_rise <= 1'b0;
      status_fall <= 1'b0;
      timeout_err <= 1'b0;
      // A request that starts this poll is consumed by the IDLE branch below.
      if (poll_now) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            read_q  <= 1'b1;
            pending <= 1'b0;
          end
        end
        REQ: begin
          if (!avm.avm_waitrequest) begin
            read_q   <= 1'b0;
            wait_cnt <= TO_W'(1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (avm.avm_readdatavalid) begin
            sample <= avm.avm_readdata[0];
            state  <= EVAL;
          end else if (wait_cnt == TO_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EVAL: begin
          state <= IDLE;
          if (!status_valid) begin
            status       <= sample;
            status_valid <= 1'b1;
          end else if (sample == status) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DB_W'(STABLE_COUNT - 1)) begin
            status      <= sample;
            status_rise <= sample;
            status_fall <= ~sample;
            deb_cnt     <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POLLER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (status_rise || status_fall || timeout_err) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ulight_fifo_status_poller.sv
// Scoreboard bench: a scripted Avalon slave queues expected poll results at accept time.
module tb_ulight_fifo_status_poller;

  localparam int P  = 32;
  localparam int TO = 16;
  localparam int SC = 2;
  localparam int NPOLL = 17;

  typedef struct {
    bit d;
    int w;
    int lat;
    bit drop;
    bit pn;
  } cfg_t;

  typedef struct {
    int due;
    bit st;
    bit vl;
    bit rs;
    bit fl;
    bit to;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic poll_now = 1'b0;
  logic status, status_valid, status_rise, status_fall, timeout_err;
`ifdef POLLER_IRQ_EN
  logic irq;
  logic irq_ack = 1'b0;
`endif

  ulight_fifo_status_poller_if avm_if ();

  ulight_fifo_status_poller #(
    .POLL_PERIOD (P),
    .TIMEOUT     (TO),
    .STABLE_COUNT(SC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .poll_now    (poll_now),
    .avm         (avm_if.master),
    .status      (status),
    .status_valid(status_valid),
    .status_rise (status_rise),
    .status_fall (status_fall),
    .timeout_err (timeout_err)
`ifdef POLLER_IRQ_EN
    ,
    .irq         (irq),
    .irq_ack     (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) if (reset_n) cyc <= cyc + 1;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  cfg_t cfgq[$];
  exp_t sb[$];
  int   reqs = 0;

  // Slave model plus reference debounce model.
  initial begin
    cfg_t cur;
    exp_t e;
    bit   in_xfer = 0;
    int   held = 0, req_start = 0, exp_start = 0;
    int   rdv_at = -1, pn1 = -1, pn2 = -1, post_acc = -1;
    bit   m_st = 0, m_vl = 0;
    int   m_cnt = 0;
    logic [31:0] rd;
    avm_if.avm_waitrequest   = 1'b0;
    avm_if.avm_readdatavalid = 1'b0;
    avm_if.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      avm_if.avm_readdatavalid = 1'b0;
      poll_now = 1'b0;
      rd = $urandom;
      if (cyc == rdv_at) begin
        rd[0] = cur.d;
        avm_if.avm_readdatavalid = 1'b1;
      end
      avm_if.avm_readdata = rd;
      if (cyc == pn1 || cyc == pn2) poll_now = 1'b1;
      if (cyc == post_acc) check("read_drop", avm_if.avm_read, 1'b0);
      if (reset_n && avm_if.avm_read) begin
        if (!in_xfer) begin
          if (cfgq.size() == 0) begin
            check("unexpected_read", avm_if.avm_read, 1'b0);
            cur = '{d: 0, w: 0, lat: 1, drop: 0, pn: 0};
          end else begin
            cur = cfgq.pop_front();
          end
          in_xfer = 1;
          held = 0;
          reqs++;
          if (reqs > 1) check("poll_start", cyc, exp_start);
          req_start = cyc;
        end
        held++;
        check("address", avm_if.avm_address, 2'd0);
        if (held <= cur.w) begin
          avm_if.avm_waitrequest = 1'b1;
        end else begin
          avm_if.avm_waitrequest = 1'b0;
          in_xfer = 0;
          check("read_held", held, cur.w + 1);
          post_acc = cyc + 1;
          e = '{due: 0, st: 0, vl: 0, rs: 0, fl: 0, to: 0};
          if (cur.drop) begin
            e.due = cyc + 1 + TO;
            e.to  = 1;
          end else begin
            rdv_at = cyc + cur.lat;
            e.due  = cyc + cur.lat + 2;
            if (!m_vl) begin
              m_st = cur.d;
              m_vl = 1;
            end else if (cur.d == m_st) begin
              m_cnt = 0;
            end else begin
              m_cnt++;
              if (m_cnt == SC) begin
                m_st  = cur.d;
                e.rs  = cur.d;
                e.fl  = !cur.d;
                m_cnt = 0;
              end
            end
          end
          e.st = m_st;
          e.vl = m_vl;
          sb.push_back(e);
          if (cur.pn) begin
            pn1 = cyc + 1;
            pn2 = cyc + 3;
            exp_start = cyc + cur.lat + 3;
          end else begin
            exp_start = req_start + P;
          end
        end
      end else begin
        avm_if.avm_waitrequest = 1'b0;
      end
    end
  end

  // Output monitor: pops expectations when their result is due.
  initial begin
    exp_t r;
    int irq_chk = -1, irq_clr = -1;
    forever begin
      @(negedge clk);
`ifdef POLLER_IRQ_EN
      irq_ack = 1'b0;
      if (cyc == irq_clr) check("irq_clear", irq, 1'b0);
      if (cyc == irq_chk) begin
        check("irq_set", irq, 1'b1);
        irq_ack = 1'b1;
        irq_clr = cyc + 1;
      end
`endif
      if (reset_n) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
          r = sb.pop_front();
          check("status", status, r.st);
          check("status_valid", status_valid, r.vl);
          check("status_rise", status_rise, r.rs);
          check("status_fall", status_fall, r.fl);
          check("timeout_err", timeout_err, r.to);
          if (r.rs || r.fl || r.to) irq_chk = cyc + 1;
        end else begin
          check("stray_pulse", {status_rise, status_fall, timeout_err}, 3'b000);
        end
      end
    end
  end

  initial begin
    int i;
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 1, w: 5, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 1, pn: 0});
    cfgq.push_back('{d: 1, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 4, drop: 0, pn: 1});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});
    cfgq.push_back('{d: 0, w: 0, lat: 1, drop: 0, pn: 0});

    repeat (3) @(negedge clk);
    check("rst_status", status, 1'b0);
    check("rst_valid", status_valid, 1'b0);
    check("rst_read", avm_if.avm_read, 1'b0);
    check("rst_pulses", {status_rise, status_fall, timeout_err}, 3'b000);
`ifdef POLLER_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    check("first_read_cycle", avm_if.avm_read, 1'b1);

    i = 0;
    while (reqs < NPOLL && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("all_polls_started", reqs, NPOLL);
    enable = 1'b0;
    repeat (3 * P) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("idle_when_disabled", avm_if.avm_read, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
